uart_transceiver_cfg: RTL and testbench

Runtime-configurable UART transceiver, successor to the fixed 8N1 transceiver.
Supports 5–8 data bits, none/even/odd parity, 1 or 2 stop bits and a parametrised oversampling ratio.
RX uses 3-sample majority voting and reports parity, framing and break conditions.
Sits between the CSR-side UART register block and the board pins, in the sys_clk domain.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_transceiver_cfg_baud_gen.sv | 32 +++
 rtl/uart_transceiver_cfg.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_transceiver_cfg.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the configurable UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } par_mode_t;

  typedef enum logic [1:0] {
    DBITS_5 = 2'd0,
    DBITS_6 = 2'd1,
    DBITS_7 = 2'd2,
    DBITS_8 = 2'd3
  } dbits_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_t;

  // Number of data bits for a data-bit encoding.
  function automatic logic [3:0] nbits(input logic [1:0] cfg);
    return {2'b00, cfg} + 4'd5;
  endfunction

  // Mask selecting the data bits actually carried in a frame.
  function automatic logic [7:0] data_mask(input logic [1:0] cfg);
    return 8'hFF >> (2'd3 - cfg);
  endfunction

  // Reserved parity encoding behaves as no parity.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_transceiver_cfg_baud_gen.sv
// Enable-tick generator: down-counter reloading max(divisor,1)-1.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  output logic             enable_tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  // Reload value; a divisor of 0 behaves like 1.
  always_comb begin
    reload = (divisor == '0) ? '0 : divisor - DIV_W'(1);
  end

  assign enable_tick = (cnt == '0);

  // Count down, reloading on each tick so divisor changes apply at reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= reload;
    end else if (enable_tick) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_transceiver_cfg.sv
// Runtime-configurable UART transceiver (5-8 data bits, N/E/O parity,
// 1/2 stop bits) with 3-sample majority RX and break detection.
module uart_transceiver_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             uart_rxd,
  output logic             uart_txd,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic [7:0]       rx_data,
  output logic             rx_done,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_break,
  input  logic [7:0]       tx_data,
  input  logic             tx_wr,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] SMP0    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SMP1    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SMP2    = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic tick;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .divisor     (divisor),
    .enable_tick (tick)
  );

  // ---------------- RX ----------------
  logic [1:0]      rx_sync;
  logic [1:0]      rx_settle;
  logic            rx_armed;
  logic            rxd_s;
  rx_state_t       rx_state;
  logic [OS_W-1:0] rx_os;
  logic [3:0]      rx_bits;
  logic [7:0]      rx_sh;
  logic [1:0]      rx_smp;
  logic [1:0]      rx_nb;
  logic [1:0]      rx_pm;
  logic            rx_par_bit;
  logic            rx_any_one;
  logic            rx_maj;
  logic            rx_par_err;

  assign rxd_s = rx_sync[1];

  // Synchronise rxd; arm start detection only once a real high has been seen
  // after reset, so a line held low through reset cannot start a frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_sync   <= '1;
      rx_settle <= '0;
      rx_armed  <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], uart_rxd};
      rx_settle <= {rx_settle[0], 1'b1};
      if (rx_settle[1] && rxd_s) rx_armed <= 1'b1;
    end
  end

  // Majority vote of the two stored samples and the live one; parity check.
  always_comb begin
    rx_maj     = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rxd_s) | (rx_smp[1] & rxd_s);
    rx_par_err = parity_on(rx_pm) &&
                 (rx_par_bit != ((^rx_sh) ^ (rx_pm == PAR_ODD)));
  end

  // RX frame FSM: bits decided at the third sample tick, stepped at bit end.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state      <= RX_IDLE;
      rx_os         <= '0;
      rx_bits       <= '0;
      rx_sh         <= '0;
      rx_smp        <= '0;
      rx_nb         <= '0;
      rx_pm         <= '0;
      rx_par_bit    <= 1'b0;
      rx_any_one    <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      if (tick) begin
        case (rx_state)
          RX_IDLE: begin
            if (rx_armed && !rxd_s) begin
              rx_nb      <= cfg_data_bits;
              rx_pm      <= cfg_parity;
              rx_os      <= '0;
              rx_bits    <= '0;
              rx_sh      <= '0;
              rx_par_bit <= 1'b0;
              rx_any_one <= 1'b0;
              rx_state   <= RX_START;
            end
          end
          RX_WAIT_IDLE: begin
            if (rxd_s) rx_state <= RX_IDLE;
          end
          default: begin
            rx_os <= rx_os + OS_W'(1);
            if (rx_os == SMP0) rx_smp[0] <= rxd_s;
            if (rx_os == SMP1) rx_smp[1] <= rxd_s;
            if (rx_os == SMP2) begin
              case (rx_state)
                RX_START: begin
                  if (rx_maj) rx_state <= RX_IDLE;
                end
                RX_DATA: begin
                  rx_sh[rx_bits[2:0]] <= rx_maj;
                  rx_bits             <= rx_bits + 4'd1;
                  if (rx_maj) rx_any_one <= 1'b1;
                end
                RX_PARITY: begin
                  rx_par_bit <= rx_maj;
                  if (rx_maj) rx_any_one <= 1'b1;
                end
                RX_STOP: begin
                  if (rx_maj) begin
                    rx_done       <= 1'b1;
                    rx_data       <= rx_sh;
                    rx_parity_err <= rx_par_err;
                    rx_state      <= RX_IDLE;
                  end else if (!rx_any_one) begin
                    rx_break <= 1'b1;
                    rx_state <= RX_WAIT_IDLE;
                  end else begin
                    rx_done       <= 1'b1;
                    rx_frame_err  <= 1'b1;
                    rx_data       <= rx_sh;
                    rx_parity_err <= rx_par_err;
                    rx_state      <= RX_WAIT_IDLE;
                  end
                end
                default: ;
              endcase
            end
            if (rx_os == OS_LAST) begin
              case (rx_state)
                RX_START:  rx_state <= RX_DATA;
                RX_DATA: begin
                  if (rx_bits == nbits(rx_nb))
                    rx_state <= parity_on(rx_pm) ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: rx_state <= RX_STOP;
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  // ---------------- TX ----------------
  tx_state_t       tx_state;
  logic [OS_W-1:0] tx_os;
  logic [3:0]      tx_bits;
  logic [7:0]      tx_sh;
  logic [1:0]      tx_nb;
  logic            tx_par_on;
  logic            tx_par_bit;
  logic            tx_stop2_l;

  // TX frame FSM with registered line, busy and done outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state   <= TX_IDLE;
      tx_os      <= '0;
      tx_bits    <= '0;
      tx_sh      <= '0;
      tx_nb      <= '0;
      tx_par_on  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop2_l <= 1'b0;
      uart_txd   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_sh      <= tx_data & data_mask(cfg_data_bits);
            tx_nb      <= cfg_data_bits;
            tx_par_on  <= parity_on(cfg_parity);
            tx_par_bit <= (^(tx_data & data_mask(cfg_data_bits))) ^ (cfg_parity == PAR_ODD);
            tx_stop2_l <= cfg_stop2;
            tx_os      <= '0;
            tx_bits    <= '0;
            uart_txd   <= 1'b0;
            tx_busy    <= 1'b1;
            tx_state   <= TX_START;
          end
        end
        default: begin
          if (tick) begin
            tx_os <= tx_os + OS_W'(1);
            if (tx_os == OS_LAST) begin
              case (tx_state)
                TX_START: begin
                  uart_txd <= tx_sh[0];
                  tx_sh    <= tx_sh >> 1;
                  tx_bits  <= 4'd1;
                  tx_state <= TX_DATA;
                end
                TX_DATA: begin
                  if (tx_bits == nbits(tx_nb)) begin
                    if (tx_par_on) begin
                      uart_txd <= tx_par_bit;
                      tx_state <= TX_PARITY;
                    end else begin
                      uart_txd <= 1'b1;
                      tx_state <= TX_STOP1;
                    end
                  end else begin
                    uart_txd <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_bits  <= tx_bits + 4'd1;
                  end
                end
                TX_PARITY: begin
                  uart_txd <= 1'b1;
                  tx_state <= TX_STOP1;
                end
                TX_STOP1: begin
                  if (tx_stop2_l) begin
                    tx_state <= TX_STOP2;
                  end else begin
                    tx_busy  <= 1'b0;
                    tx_done  <= 1'b1;
                    tx_state <= TX_IDLE;
                  end
                end
                default: begin
                  tx_busy  <= 1'b0;
                  tx_done  <= 1'b1;
                  tx_state <= TX_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver_cfg.sv
// Directed self-checking bench for uart_transceiver_cfg (divisor 4, OVERSAMPLE 16).
module tb_uart_transceiver_cfg;

  localparam int BIT = 64;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        rxd_drv;
  logic        loop;
  logic        uart_rxd;
  logic        uart_txd;
  logic [15:0] divisor;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        rx_break;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        tx_done;

  int checks;
  int errors;

  assign uart_rxd = loop ? uart_txd : rxd_drv;

  uart_transceiver_cfg #(.DIV_W(16), .OVERSAMPLE(16)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .uart_rxd      (uart_rxd),
    .uart_txd      (uart_txd),
    .divisor       (divisor),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_break      (rx_break),
    .tx_data       (tx_data),
    .tx_wr         (tx_wr),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // Pulse monitor sampled on the falling edge.
  int         n_done = 0;
  int         n_break = 0;
  int         n_txdone = 0;
  logic [7:0] last_data = '0;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;
  always @(negedge sys_clk) begin
    if (rx_done === 1'b1) begin
      n_done++;
      last_data = rx_data;
      last_perr = rx_parity_err;
      last_ferr = rx_frame_err;
    end
    if (rx_break === 1'b1) n_break++;
    if (tx_done === 1'b1) n_txdone++;
  end

  task automatic set_cfg(input logic [1:0] nb, input logic [1:0] par, input logic s2);
    @(negedge sys_clk);
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = s2;
  endtask

  task automatic rx_bit(input logic v, input logic glitch);
    rxd_drv = v;
    if (glitch) begin
      repeat (34) @(negedge sys_clk);
      rxd_drv = ~v;
      repeat (4) @(negedge sys_clk);
      rxd_drv = v;
      repeat (BIT - 38) @(negedge sys_clk);
    end else begin
      repeat (BIT) @(negedge sys_clk);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input int nb, input int par,
                             input logic flip, input logic stop_v, input int gbit);
    logic p;
    p = flip;
    rx_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) begin
      rx_bit(d[i], i == gbit);
      p = p ^ d[i];
    end
    if (par == 1 || par == 2) begin
      if (par == 2) p = ~p;
      rx_bit(p, 1'b0);
    end
    rx_bit(stop_v, 1'b0);
    rxd_drv = 1'b1;
  endtask

  task automatic tx_kick(input logic [7:0] d);
    @(negedge sys_clk);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge sys_clk);
    tx_wr   = 1'b0;
  endtask

  // Samples nbits mid-bit values starting at the start-bit fall, returns at tx_done.
  task automatic tx_capture(input int nbits_tot, output logic [15:0] bits, output int len);
    int fall;
    int k;
    bits = '0;
    len  = 0;
    k    = 0;
    while (uart_txd !== 1'b0 && k < 2000) begin
      @(negedge sys_clk);
      k++;
    end
    if (uart_txd !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL tx_start_timeout: txd=%b required 0 within 2000 cycles", uart_txd);
      return;
    end
    fall = cyc;
    repeat (32) @(negedge sys_clk);
    bits[0] = uart_txd;
    for (int i = 1; i < nbits_tot; i++) begin
      repeat (BIT) @(negedge sys_clk);
      bits[i] = uart_txd;
    end
    k = 0;
    while (tx_done !== 1'b1 && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    if (tx_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tx_done_timeout: tx_done=%b required 1 within 200 cycles", tx_done);
    end
    len = cyc - fall;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b required 0", rx_done); end
    checks++; if (rx_break !== 1'b0) begin errors++; $display("FAIL reset_rx_break: got %b required 0", rx_break); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b required 0", tx_done); end
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
  endtask

  task automatic test_rx_8n1;
    int b;
    set_cfg(2'd3, 2'd0, 1'b0);
    b = n_done;
    drive_frame(8'hA5, 8, 0, 1'b0, 1'b1, -1);
    repeat (20) @(negedge sys_clk);
    checks++; if (n_done - b !== 1) begin errors++; $display("FAIL rx8n1_count: got %0d required 1", n_done - b); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL rx8n1_data: got %h required a5", last_data); end
    checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL rx8n1_perr: got %b required 0", last_perr); end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL rx8n1_ferr: got %b required 0", last_ferr); end
  endtask

  task automatic test_tx_8n1;
    logic [15:0] bits;
    int len, bd, bt;
    set_cfg(2'd3, 2'd0, 1'b0);
    loop = 1'b1;
    bd = n_done;
    bt = n_txdone;
    tx_kick(8'h3C);
    tx_capture(10, bits, len);
    repeat (20) @(negedge sys_clk);
    checks++; if (bits !== 16'h0278) begin errors++; $display("FAIL tx8n1_bits: got %h required 0278", bits); end
    checks++; if (len < 637 || len > 640) begin errors++; $display("FAIL tx8n1_len: got %0d required 637..640", len); end
    checks++; if (n_txdone - bt !== 1) begin errors++; $display("FAIL tx8n1_done_count: got %0d required 1", n_txdone - bt); end
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL tx8n1_loop_count: got %0d required 1", n_done - bd); end
    checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL tx8n1_loop_data: got %h required 3c", last_data); end
    loop = 1'b0;
  endtask

  task automatic test_7e2;
    logic [15:0] bits;
    int len, bd;
    set_cfg(2'd2, 2'd1, 1'b1);
    loop = 1'b1;
    bd = n_done;
    tx_kick(8'h55);
    tx_capture(11, bits, len);
    repeat (20) @(negedge sys_clk);
    checks++; if (bits !== 16'h06AA) begin errors++; $display("FAIL tx7e2_bits: got %h required 06aa", bits); end
    checks++; if (len < 701 || len > 704) begin errors++; $display("FAIL tx7e2_len: got %0d required 701..704", len); end
    checks++; if (last_data !== 8'h55 || n_done - bd !== 1) begin errors++; $display("FAIL rx7e2_loop: got %h/%0d required 55/1", last_data, n_done - bd); end
    checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL rx7e2_perr: got %b required 0", last_perr); end
    loop = 1'b0;
    bd = n_done;
    drive_frame(8'h55, 7, 1, 1'b1, 1'b1, -1);
    repeat (20) @(negedge sys_clk);
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL rx7e2_bad_count: got %0d required 1", n_done - bd); end
    checks++; if (last_perr !== 1'b1) begin errors++; $display("FAIL rx7e2_bad_perr: got %b required 1", last_perr); end
    checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL rx7e2_bad_data: got %h required 55", last_data); end
  endtask

  task automatic test_frame_err;
    int bd;
    set_cfg(2'd3, 2'd0, 1'b0);
    bd = n_done;
    drive_frame(8'h81, 8, 0, 1'b0, 1'b0, -1);
    repeat (BIT) @(negedge sys_clk);
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL ferr_count: got %0d required 1", n_done - bd); end
    checks++; if (last_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b required 1", last_ferr); end
    checks++; if (last_data !== 8'h81) begin errors++; $display("FAIL ferr_data: got %h required 81", last_data); end
    checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL ferr_perr: got %b required 0", last_perr); end
  endtask

  task automatic test_break;
    int bd, bb;
    bd = n_done;
    bb = n_break;
    rxd_drv = 1'b0;
    repeat (20 * BIT) @(negedge sys_clk);
    checks++; if (n_break - bb !== 1) begin errors++; $display("FAIL break_count: got %0d required 1", n_break - bb); end
    repeat (10 * BIT) @(negedge sys_clk);
    checks++; if (n_break - bb !== 1) begin errors++; $display("FAIL break_held_count: got %0d required 1", n_break - bb); end
    checks++; if (n_done - bd !== 0) begin errors++; $display("FAIL break_no_done: got %0d required 0", n_done - bd); end
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL break_data_kept: got %h required 81", rx_data); end
    rxd_drv = 1'b1;
    repeat (2 * BIT) @(negedge sys_clk);
    drive_frame(8'h42, 8, 0, 1'b0, 1'b1, -1);
    repeat (20) @(negedge sys_clk);
    checks++; if (n_done - bd !== 1 || last_data !== 8'h42) begin errors++; $display("FAIL break_recover: got %0d/%h required 1/42", n_done - bd, last_data); end
  endtask

  task automatic test_glitch;
    int bd;
    bd = n_done;
    rxd_drv = 1'b0;
    repeat (8) @(negedge sys_clk);
    rxd_drv = 1'b1;
    repeat (3 * BIT) @(negedge sys_clk);
    checks++; if (n_done - bd !== 0) begin errors++; $display("FAIL glitch_false_start: got %0d done required 0", n_done - bd); end
    drive_frame(8'h5A, 8, 0, 1'b0, 1'b1, 3);
    repeat (20) @(negedge sys_clk);
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL glitch_hi_count: got %0d required 1", n_done - bd); end
    checks++; if (last_data !== 8'h5A) begin errors++; $display("FAIL glitch_hi_data: got %h required 5a", last_data); end
    drive_frame(8'h5A, 8, 0, 1'b0, 1'b1, 0);
    repeat (20) @(negedge sys_clk);
    checks++; if (n_done - bd !== 2) begin errors++; $display("FAIL glitch_lo_count: got %0d required 2", n_done - bd); end
    checks++; if (last_data !== 8'h5A) begin errors++; $display("FAIL glitch_lo_data: got %h required 5a", last_data); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] bits;
    int len, bd, bt;
    set_cfg(2'd3, 2'd0, 1'b0);
    loop = 1'b1;
    bd = n_done;
    bt = n_txdone;
    tx_kick(8'h3C);
    fork
      tx_capture(10, bits, len);
      begin
        repeat (300) @(negedge sys_clk);
        tx_data = 8'hFF;
        tx_wr   = 1'b1;
        @(negedge sys_clk);
        tx_wr   = 1'b0;
      end
    join
    tx_data = 8'h96;
    tx_wr   = 1'b1;
    @(negedge sys_clk);
    tx_wr   = 1'b0;
    checks++; if (bits !== 16'h0278) begin errors++; $display("FAIL busy_ignore_bits: got %h required 0278", bits); end
    checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL b2b_start_txd: got %b required 0", uart_txd); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b required 1", tx_busy); end
    tx_capture(10, bits, len);
    repeat (20) @(negedge sys_clk);
    checks++; if (bits !== 16'h032C) begin errors++; $display("FAIL b2b_bits: got %h required 032c", bits); end
    checks++; if (n_txdone - bt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", n_txdone - bt); end
    checks++; if (n_done - bd !== 2) begin errors++; $display("FAIL b2b_rx_count: got %0d required 2", n_done - bd); end
    checks++; if (last_data !== 8'h96) begin errors++; $display("FAIL b2b_rx_data: got %h required 96", last_data); end
    loop = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int bd, bb, bt;
    set_cfg(2'd3, 2'd0, 1'b0);
    loop = 1'b1;
    tx_kick(8'hAA);
    repeat (300) @(negedge sys_clk);
    bd = n_done;
    bb = n_break;
    bt = n_txdone;
    sys_rst_n = 1'b0;
    #1;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b required 1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b required 0", tx_busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data: got %h required 00", rx_data); end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    loop = 1'b0;
    repeat (3 * BIT) @(negedge sys_clk);
    checks++; if (n_done - bd !== 0 || n_break - bb !== 0 || n_txdone - bt !== 0) begin
      errors++;
      $display("FAIL rst_mid_pulses: got done=%0d break=%0d txdone=%0d required 0/0/0", n_done - bd, n_break - bb, n_txdone - bt);
    end
    set_cfg(2'd0, 2'd2, 1'b0);
    bd = n_done;
    drive_frame(8'h1F, 5, 2, 1'b0, 1'b1, -1);
    repeat (20) @(negedge sys_clk);
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL rx5o1_count: got %0d required 1", n_done - bd); end
    checks++; if (last_data !== 8'h1F) begin errors++; $display("FAIL rx5o1_data: got %h required 1f", last_data); end
    checks++; if (last_perr !== 1'b0 || last_ferr !== 1'b0) begin errors++; $display("FAIL rx5o1_flags: got perr=%b ferr=%b required 0/0", last_perr, last_ferr); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    sys_rst_n     = 1'b0;
    rxd_drv       = 1'b1;
    loop          = 1'b0;
    divisor       = 16'd4;
    cfg_data_bits = 2'd3;
    cfg_parity    = 2'd0;
    cfg_stop2     = 1'b0;
    tx_data       = 8'h00;
    tx_wr         = 1'b0;
    test_reset();
    test_rx_8n1();
    test_tx_8n1();
    test_7e2();
    test_frame_err();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
